// File: rtl/scircuit6_pkg.sv
// Shared types and defaults for the scheduled z = MUX(a%c==zero, a-1, c+1) controller.
package scircuit6_pkg;

    localparam int unsigned DEF_DATAWIDTH = 64;

    typedef enum logic [2:0] {
        S_WAIT     = 3'd0,
        S_DEC      = 3'd1,
        S_INC      = 3'd2,
        S_MOD_GO   = 3'd3,
        S_MOD_WAIT = 3'd4,
        S_CMP      = 3'd5,
        S_FINAL    = 3'd6
    } state_t;

endpackage

// File: rtl/scircuit6_hlsm_ctrl_smod_iter.sv
// Iterative signed modulo (Verilog % semantics): restoring shift-subtract on magnitudes,
// one quotient bit per edge, remainder takes the dividend's sign.
module smod_iter
    import scircuit6_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [DATAWIDTH-1:0] dividend,
    input  logic [DATAWIDTH-1:0] divisor,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 done
);

    localparam int unsigned W  = DATAWIDTH;
    localparam int unsigned CW = $clog2(W + 1);

    logic          busy_r;
    logic          done_r;
    logic          neg_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  q_r;
    logic [W-1:0]  d_r;
    logic [W-1:0]  r_r;
    logic [W-1:0]  rem_r;

    logic [W-1:0]  dvd_mag;
    logic [W-1:0]  dvs_mag;
    logic [W:0]    r_sh;
    logic [W:0]    r_dif;
    logic [W-1:0]  r_nxt;
    logic [W-1:0]  r_fix;

    // Magnitudes are unsigned W-bit, so the most negative value maps to 2^(W-1) exactly.
    always_comb begin
        dvd_mag = dividend[W-1] ? W'(-dividend) : dividend;
        dvs_mag = divisor[W-1]  ? W'(-divisor)  : divisor;
        r_sh    = {r_r, q_r[W-1]};
        r_dif   = r_sh - {1'b0, d_r};
        r_nxt   = r_dif[W] ? r_sh[W-1:0] : r_dif[W-1:0];
        r_fix   = neg_r ? W'(-r_nxt) : r_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            neg_r  <= 1'b0;
            cnt_r  <= '0;
            q_r    <= '0;
            d_r    <= '0;
            r_r    <= '0;
            rem_r  <= '0;
        end else begin
            done_r <= 1'b0;
            if (busy_r) begin
                q_r   <= {q_r[W-2:0], 1'b0};
                r_r   <= r_nxt;
                cnt_r <= cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    rem_r  <= r_fix;
                end
            end else if (go) begin
                neg_r <= dividend[W-1];
                q_r   <= dvd_mag;
                d_r   <= dvs_mag;
                r_r   <= '0;
                cnt_r <= CW'(W);
                // Zero divisor: remainder is the dividend itself, no iterations.
                if (divisor == '0) begin
                    done_r <= 1'b1;
                    rem_r  <= dividend;
                end else begin
                    busy_r <= 1'b1;
                end
            end
        end
    end

    assign rem  = rem_r;
    assign done = done_r;

endmodule

// File: rtl/scircuit6_hlsm_ctrl.sv
// Scheduled controller for z = (a%c == zero) ? c+1 : a-1 using one shared adder
// and an iterative modulo unit under a Start/Done handshake.
module scircuit6_hlsm_ctrl
    import scircuit6_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    input  logic [DATAWIDTH-1:0] zero,
    output logic [DATAWIDTH-1:0] z,
    output logic                 Done,
    output logic                 Busy,
    output logic                 DivByZero
);

    localparam int unsigned W = DATAWIDTH;

    state_t        state_r;
    state_t        state_nxt;

    logic [W-1:0]  a_r, c_r, zero_r, e_r, f_r, g_r, z_r;
    logic          done_r, busy_r, dbz_r;

    logic          cap_c, ld_e_c, ld_f_c, go_c, ld_g_c, ld_z_c;
    logic [W-1:0]  add_x_c, add_y_c, sum_c;

    logic          mod_done;
    logic [W-1:0]  mod_rem;
    logic          b_unused;

    assign b_unused = ^b;

    smod_iter #(.DATAWIDTH(W)) u_smod (
        .clk      (clk),
        .rst      (rst),
        .go       (go_c),
        .dividend (a_r),
        .divisor  (c_r),
        .rem      (mod_rem),
        .done     (mod_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state_r <= S_WAIT;
        else     state_r <= state_nxt;
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_WAIT:     if (Start) state_nxt = S_DEC;
            S_DEC:      state_nxt = S_INC;
            S_INC:      state_nxt = S_MOD_GO;
            S_MOD_GO:   state_nxt = S_MOD_WAIT;
            S_MOD_WAIT: if (mod_done) state_nxt = S_CMP;
            S_CMP:      state_nxt = S_FINAL;
            S_FINAL:    state_nxt = S_WAIT;
            default:    state_nxt = S_WAIT;
        endcase
    end

    // Per-state datapath controls; the shared adder's operands follow the state.
    always_comb begin
        cap_c   = 1'b0;
        ld_e_c  = 1'b0;
        ld_f_c  = 1'b0;
        go_c    = 1'b0;
        ld_g_c  = 1'b0;
        ld_z_c  = 1'b0;
        add_x_c = a_r;
        add_y_c = '1;
        case (state_r)
            S_WAIT:     cap_c = Start;
            S_DEC:      ld_e_c = 1'b1;
            S_INC: begin
                ld_f_c  = 1'b1;
                add_x_c = c_r;
                add_y_c = W'(1);
            end
            S_MOD_GO:   go_c = 1'b1;
            S_MOD_WAIT: ld_g_c = mod_done;
            S_CMP:      ld_z_c = 1'b1;
            default:    ;
        endcase
    end

    assign sum_c = add_x_c + add_y_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            c_r    <= '0;
            zero_r <= '0;
            e_r    <= '0;
            f_r    <= '0;
            g_r    <= '0;
            z_r    <= '0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            // Status flags are registered from the next state so they line up with it.
            done_r <= (state_nxt == S_FINAL);
            busy_r <= (state_nxt != S_WAIT);
            if (cap_c) begin
                a_r    <= a;
                c_r    <= c;
                zero_r <= zero;
                dbz_r  <= 1'b0;
            end
            if (ld_e_c) e_r <= sum_c;
            if (ld_f_c) f_r <= sum_c;
            if (go_c)   dbz_r <= (c_r == '0);
            if (ld_g_c) g_r <= mod_rem;
            if (ld_z_c) z_r <= (g_r == zero_r) ? f_r : e_r;
        end
    end

    assign z         = z_r;
    assign Done      = done_r;
    assign Busy      = busy_r;
    assign DivByZero = dbz_r;

endmodule

// File: tb/tb_scircuit6_hlsm_ctrl.sv
// Scoreboard bench: driver pushes expected z/flag/latency per accepted Start, monitor checks on Done.
module tb_scircuit6_hlsm_ctrl;

    localparam int W = 64;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [63:0] z;
        logic        dbz;
        int          lat;
        int          t0;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          Start;
    logic [W-1:0]  a, b, c, zero;
    logic [W-1:0]  z;
    logic          Done, Busy, DivByZero;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    scircuit6_hlsm_ctrl #(.DATAWIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .a         (a),
        .b         (b),
        .c         (c),
        .zero      (zero),
        .z         (z),
        .Done      (Done),
        .Busy      (Busy),
        .DivByZero (DivByZero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && Done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got z=%0h with nothing outstanding (cyc %0d)", z, cyc);
            end else begin
                e = sb.pop_front();
                chk("z", z, e.z);
                chk("divbyzero", 64'(DivByZero), 64'(e.dbz));
                chk("latency", 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    task automatic start_op(input logic [63:0] ia, input logic [63:0] ic, input logic [63:0] iz,
                            input logic [63:0] ez, input logic edbz, input int elat);
        exp_t e;
        @(negedge clk);
        a = ia; c = ic; zero = iz; b = 64'($urandom); Start = 1'b1;
        e.z = ez; e.dbz = edbz; e.lat = elat; e.t0 = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        Start = 1'b0;
        a = {$urandom, $urandom}; c = {$urandom, $urandom}; zero = {$urandom, $urandom};
        chk("dbz_cleared_on_start", 64'(DivByZero), 64'(0));
        chk("busy_after_start", 64'(Busy), 64'(1));
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!Busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got busy=1 want busy=0 within 300 cycles", name);
        end
    endtask

    initial begin
        int t0;
        rst = 1'b1; Start = 1'b0; a = '0; b = '0; c = '0; zero = '0;
        repeat (3) @(negedge clk);
        chk("reset_z", z, 64'(0));
        chk("reset_done", 64'(Done), 64'(0));
        chk("reset_busy", 64'(Busy), 64'(0));
        chk("reset_dbz", 64'(DivByZero), 64'(0));
        rst = 1'b0;

        // 17 % 5 = 2 == zero -> c+1
        start_op(64'd17, 64'd5, 64'd2, 64'd6, 1'b0, W + 5);
        wait_idle("op1");
        chk("z_hold_after_done", z, 64'd6);
        // -17 % 5 = -2 != 2 -> a-1
        start_op(-64'sd17, 64'd5, 64'd2, -64'sd18, 1'b0, W + 5);
        wait_idle("op2");
        // Divisor zero: rem = a = 7 -> c+1 = 1, short latency
        start_op(64'd7, 64'd0, 64'd7, 64'd1, 1'b1, 5);
        wait_idle("op3");
        chk("dbz_held", 64'(DivByZero), 64'(1));
        // Flag cleared by the next accepted Start (checked inside start_op)
        start_op(64'd10, 64'd3, 64'd0, 64'd9, 1'b0, W + 5);
        wait_idle("op3b");
        // Most negative dividend: rem = -1 == zero -> c+1 wraps to MIN
        start_op(MINV, MAXV, 64'hFFFF_FFFF_FFFF_FFFF, MINV, 1'b0, W + 5);
        wait_idle("op4");
        // Negative divisor: 20 % -6 = 2 == 2 -> c+1 = -5
        start_op(64'd20, -64'sd6, 64'd2, -64'sd5, 1'b0, W + 5);
        wait_idle("op4b");

        // Start re-pulsed mid-op is ignored; Busy stays high until Done
        start_op(64'd100, 64'd7, 64'd2, 64'd8, 1'b0, W + 5);
        repeat (8) @(negedge clk);
        a = 64'd5; c = 64'd3; zero = 64'd2; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        for (int i = 0; i < 300 && !Done; i++) begin
            if (!Busy) begin
                chk("busy_during_op", 64'(Busy), 64'(1));
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        chk("busy_low_in_wait", 64'(Busy), 64'(0));
        chk("z_first_op_kept", z, 64'd8);

        // Start held high: second op accepted W+7 edges after the first
        @(negedge clk);
        a = 64'd17; c = 64'd5; zero = 64'd3; Start = 1'b1;
        t0 = cyc + 1;
        sb.push_back('{64'd16, 1'b0, W + 5, t0});
        sb.push_back('{-64'sd5, 1'b0, W + 5, t0 + W + 7});
        @(negedge clk);
        a = 64'd20; c = -64'sd6; zero = 64'd2;
        while (cyc < t0 + W + 7) @(negedge clk);
        Start = 1'b0;
        a = '0; c = '0; zero = '0;
        wait_idle("b2b");

        // Reset at edge 30 of an op: no Done, everything cleared
        @(negedge clk);
        a = 64'd50; c = 64'd9; zero = 64'd5; Start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        Start = 1'b0;
        while (cyc < t0 + 29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midop_rst_z", z, 64'(0));
        chk("midop_rst_busy", 64'(Busy), 64'(0));
        chk("midop_rst_done", 64'(Done), 64'(0));
        repeat (80) @(negedge clk);
        chk("midop_rst_still_idle", 64'(Busy), 64'(0));
        // Fresh op after reset: 50 % 9 = 5 == 5 -> c+1 = 10
        start_op(64'd50, 64'd9, 64'd5, 64'd10, 1'b0, W + 5);
        wait_idle("post_rst");

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish by 1000000");
        $fatal(1);
    end

endmodule
